// File: rtl/breathe_sequencer_pkg.sv
// Shared types and constants for the breathe colour sequencer.
// Colour masks: bit0 = red, bit1 = green, bit2 = blue; a set bit means the channel breathes.
package breathe_seq_pkg;

    typedef logic [2:0] rgb_mask_t;

    localparam rgb_mask_t RED     = 3'b001;
    localparam rgb_mask_t GREEN   = 3'b010;
    localparam rgb_mask_t BLUE    = 3'b100;
    localparam rgb_mask_t YELLOW  = 3'b011;
    localparam rgb_mask_t MAGENTA = 3'b101;
    localparam rgb_mask_t CYAN    = 3'b110;
    localparam rgb_mask_t WHITE   = 3'b111;
    localparam rgb_mask_t OFF     = 3'b000;

    // Channel-reset vector that holds every breathe instance off.
    localparam rgb_mask_t CHAN_ALL_RST = 3'b111;

    localparam int CYC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESYNC,
        ST_RUN,
        ST_PAUSE
    } seq_state_t;

    localparam int DEFAULT_TABLE_LEN = 8;
    localparam rgb_mask_t DEFAULT_TABLE [DEFAULT_TABLE_LEN] =
        '{BLUE, GREEN, RED, YELLOW, MAGENTA, CYAN, WHITE, OFF};

    function automatic rgb_mask_t default_mask(input int idx);
        return (idx < DEFAULT_TABLE_LEN) ? DEFAULT_TABLE[idx[2:0]] : OFF;
    endfunction

endpackage

// File: rtl/breathe_sequencer_if.sv
// Control, configuration and output bundle of the breathe sequencer.
// The slave modport is the sequencer's view; the master modport is the controller's.
interface breathe_sequencer_if
    import breathe_seq_pkg::*;
#(
    parameter int PERIOD_W    = 24,
    parameter int NUM_ENTRIES = 8
);
    localparam int ADDR_W = $clog2(NUM_ENTRIES);

    logic                enable_i;
    logic                pause_i;
    logic                skip_i;
    logic                cfg_wr_i;
    logic [ADDR_W-1:0]   cfg_addr_i;
    rgb_mask_t           cfg_mask_i;
    logic                period_wr_i;
    logic [PERIOD_W-1:0] period_i;
    logic [PERIOD_W-1:0] period_o;
    logic [2:0]          chan_rst_o;
    logic [ADDR_W-1:0]   entry_o;
    logic                advance_o;

    modport slave (
        input  enable_i, pause_i, skip_i, cfg_wr_i, cfg_addr_i, cfg_mask_i,
               period_wr_i, period_i,
        output period_o, chan_rst_o, entry_o, advance_o
    );

    modport master (
        output enable_i, pause_i, skip_i, cfg_wr_i, cfg_addr_i, cfg_mask_i,
               period_wr_i, period_i,
        input  period_o, chan_rst_o, entry_o, advance_o
    );

endinterface

// File: rtl/breathe_timebase.sv
// clk_cnt -> step_cnt -> cyc_cnt chain; cycle_end_o flags the last clock of a breathe cycle.
// A period of zero counts exactly like a period of one.
module breathe_timebase
    import breathe_seq_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                Sys_Clk0,
    input  logic                Sys_Clk0_Rst,
    input  logic                clear_i,
    input  logic                hold_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                cycle_end_o,
    output logic [CYC_W-1:0]    cyc_cnt_o
);
    localparam int STEP_W = PWM_BITS + 1;

    logic [PERIOD_W-1:0] clk_cnt_q, clk_cnt_d, last_clk;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic                clk_wrap;
    logic                step_wrap;

    always_comb begin
        // NOTE: every signal is given a default before any branch so no path infers a latch.
        clk_cnt_d  = clk_cnt_q;
        step_cnt_d = step_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        last_clk   = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
        clk_wrap   = (clk_cnt_q >= last_clk);
        step_wrap  = &step_cnt_q;
        cycle_end_o = !clear_i && !hold_i && clk_wrap && step_wrap;

        if (clear_i) begin
            clk_cnt_d  = '0;
            step_cnt_d = '0;
            cyc_cnt_d  = '0;
        end else if (!hold_i) begin
            if (clk_wrap) begin
                clk_cnt_d  = '0;
                step_cnt_d = step_cnt_q + STEP_W'(1);
                if (step_wrap) begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end else begin
                clk_cnt_d = clk_cnt_q + PERIOD_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            clk_cnt_q  <= '0;
            step_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            step_cnt_q <= step_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;

endmodule

// File: rtl/breathe_sequencer.sv
// Pattern-table colour sequencer for the three breathe channels: advances only at breathe-cycle
// boundaries (or on skip), re-phasing every channel through a one-cycle RESYNC.
module breathe_sequencer
    import breathe_seq_pkg::*;
#(
    parameter int                PWM_BITS           = 8,
    parameter int                PERIOD_W           = 24,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD   = 24'hAAAA,
    parameter int                CYCLES_PER_PATTERN = 2,
    parameter int                NUM_ENTRIES        = 8
) (
    input  logic               Sys_Clk0,
    input  logic               Sys_Clk0_Rst,
    breathe_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_ENTRIES);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CYCLES_PER_PATTERN - 1);

    seq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   entry_q, entry_d, next_entry;
    rgb_mask_t           chan_rst_q, chan_rst_d;
    logic                advance_q, advance_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] shadow_q, shadow_d;
    logic                skip_pend_q, skip_pend_d;
    rgb_mask_t           table_q [NUM_ENTRIES];
    rgb_mask_t           table_d [NUM_ENTRIES];

    logic                cycle_end;
    logic                pattern_end;
    logic [CYC_W-1:0]    cyc_cnt;
    logic                tb_clear;
    logic                tb_hold;

    assign tb_clear = (state_q == ST_IDLE) || (state_q == ST_RESYNC);
    assign tb_hold  = (state_q == ST_PAUSE);

    breathe_timebase #(
        .PWM_BITS (PWM_BITS),
        .PERIOD_W (PERIOD_W)
    ) u_timebase (
        .Sys_Clk0     (Sys_Clk0),
        .Sys_Clk0_Rst (Sys_Clk0_Rst),
        .clear_i      (tb_clear),
        .hold_i       (tb_hold),
        .period_i     (period_q),
        .cycle_end_o  (cycle_end),
        .cyc_cnt_o    (cyc_cnt)
    );

    always_comb begin
        table_d = table_q;
        if (bus.cfg_wr_i) begin
            table_d[bus.cfg_addr_i] = bus.cfg_mask_i;
        end
        shadow_d = bus.period_wr_i ? bus.period_i : shadow_q;
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        chan_rst_d  = chan_rst_q;
        advance_d   = 1'b0;
        period_d    = period_q;
        skip_pend_d = skip_pend_q;
        next_entry  = entry_q + ADDR_W'(1);
        pattern_end = cycle_end && (cyc_cnt == LAST_CYC);

        if (!bus.enable_i) begin
            state_d     = ST_IDLE;
            entry_d     = '0;
            chan_rst_d  = CHAN_ALL_RST;
            skip_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RESYNC;
                    advance_d  = 1'b1;
                    chan_rst_d = CHAN_ALL_RST;
                end
                ST_RESYNC: begin
                    state_d    = ST_RUN;
                    chan_rst_d = ~table_q[entry_q];
                    period_d   = shadow_q;
                end
                ST_RUN: begin
                    // Skip and a natural advance in the same cycle collapse into one increment.
                    if (bus.skip_i || pattern_end) begin
                        state_d    = ST_RESYNC;
                        entry_d    = next_entry;
                        advance_d  = 1'b1;
                        chan_rst_d = CHAN_ALL_RST;
                    end else if (bus.pause_i) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.skip_i && bus.pause_i) begin
                        entry_d     = next_entry;
                        chan_rst_d  = ~table_q[next_entry];
                        skip_pend_d = 1'b1;
                    end else if (bus.skip_i || (!bus.pause_i && skip_pend_q)) begin
                        state_d     = ST_RESYNC;
                        entry_d     = bus.skip_i ? next_entry : entry_q;
                        advance_d   = 1'b1;
                        chan_rst_d  = CHAN_ALL_RST;
                        skip_pend_d = 1'b0;
                    end else if (!bus.pause_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            chan_rst_q  <= CHAN_ALL_RST;
            advance_q   <= 1'b0;
            period_q    <= DEFAULT_PERIOD;
            shadow_q    <= DEFAULT_PERIOD;
            skip_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            chan_rst_q  <= chan_rst_d;
            advance_q   <= advance_d;
            period_q    <= period_d;
            shadow_q    <= shadow_d;
            skip_pend_q <= skip_pend_d;
        end
    end

    // NOTE: the pattern table is flop-based and reset because it carries a defined default pattern.
    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                table_q[i] <= default_mask(i);
            end
        end else begin
            table_q <= table_d;
        end
    end

    assign bus.period_o   = period_q;
    assign bus.chan_rst_o = chan_rst_q;
    assign bus.entry_o    = entry_q;
    assign bus.advance_o  = advance_q;

endmodule

// File: doc/breathe_sequencer.md
# breathe_sequencer

Colour-sequence controller for the three `ONION_BREATHE` channels on the AL4S3B FPGA fabric. It replaces the fixed free-running colour counter. It holds a writable pattern table of RGB channel masks and owns the breathe period. Pattern advances occur only on breathe-cycle boundaries and re-phase all channels at each advance, so colour changes are always glitch-free. It supports run, pause, skip and runtime reconfiguration.

## Interface
Parameters:
- `PWM_BITS`, default 8: breathe PWM resolution. One breathe cycle is 2^(PWM_BITS+1) steps.
- `PERIOD_W`, default 24: width of the period (clocks per step).
- `DEFAULT_PERIOD`, default 24'hAAAA: reset value of the active period.
- `CYCLES_PER_PATTERN`, default 2: breathe cycles spent on each pattern entry. Range 1..255.
- `NUM_ENTRIES`, default 8: pattern table depth. Must be a power of 2.

Ports:
- `Sys_Clk0`, in, 1: clock.
- `Sys_Clk0_Rst`, in, 1: reset. Asynchronous, active-high.
- `enable_i`, in, 1: level input. High runs the sequence; low idles with all channels held in reset.
- `pause_i`, in, 1: level input. Freezes all counters and outputs.
- `skip_i`, in, 1: single-cycle pulse. Requests an immediate advance to the next entry.
- `cfg_wr_i`, in, 1: pattern table write strobe.
- `cfg_addr_i`, in, log2(NUM_ENTRIES): pattern table write address.
- `cfg_mask_i`, in, 3: pattern table write data. bit0 = red, bit1 = green, bit2 = blue; 1 = channel breathes.
- `period_wr_i`, in, 1: period shadow write strobe.
- `period_i`, in, PERIOD_W: new period value.
- `period_o`, out, PERIOD_W: active period, driven to every breathe instance.
- `chan_rst_o`, out, 3: per-channel reset to the breathe instances (1 = channel held off/reset).
- `entry_o`, out, log2(NUM_ENTRIES): index of the current pattern entry.
- `advance_o`, out, 1: one-cycle pulse marking each pattern advance.

## Operation
**States:**
- IDLE
  - Condition: `enable_i` = 0.
  - Behaviour: `chan_rst_o` = 3'b111; all counters are zero; `entry_o` = 0.
  - Transition: goes to RESYNC when `enable_i` rises.
- RESYNC
  - Duration: exactly 1 cycle.
  - Behaviour: `chan_rst_o` = 3'b111; counters are cleared; the shadow period is copied to `period_o`; `advance_o` = 1.
  - Transition: goes to RUN.
- RUN
  - Behaviour: `chan_rst_o` = ~table[entry]. This value is latched on entering RUN and is not affected by later table writes.
  - Counter chain:
    - `clk_cnt` runs from 0 to P-1, where P = max(`period_o`, 1).
    - `step_cnt` (PWM_BITS+1 bits) increments on each `clk_cnt` wrap.
    - `cyc_cnt` increments when `step_cnt` wraps from all-ones; this event is *cycle_end*.
  - Transitions:
    - When *cycle_end* occurs and `cyc_cnt` = CYCLES_PER_PATTERN-1: increment `entry` (mod NUM_ENTRIES) and go to RESYNC.
    - When `skip_i` = 1: increment `entry` and go to RESYNC.
    - When `pause_i` = 1: go to PAUSE.
- PAUSE
  - Behaviour: counters and outputs are frozen.
  - Transitions:
    - When `pause_i` = 0: return to RUN without resync.
    - When `skip_i` = 1: increment `entry` and latch the new mask. Remain in PAUSE; RESYNC happens on resume.

**Configuration:**
- `enable_i` = 0 from any state: go to IDLE on the next cycle and reset `entry` to 0.
- Table writes are accepted in any state and take effect at the next mask latch.
- Period writes go to a shadow register. They are applied to `period_o` only in RESYNC, never mid-cycle.

**Priority of simultaneous events** (highest first): reset, then `!enable_i`, then `skip_i`, then natural advance, then `pause_i`.
- A simultaneous natural advance and skip produce a single increment.

**Entry values:**
- An entry of 3'b000 gives all channels off for its full duration.

**Reset values:**
- Table entries 0..7: 100, 010, 001, 011, 101, 110, 111, 000. Entries beyond index 7 reset to 000.
- `period_o` = DEFAULT_PERIOD.
- `chan_rst_o` = 3'b111.
- `entry_o` = 0.
- `advance_o` = 0.
- Shadow period = DEFAULT_PERIOD.
- State = IDLE.

## Timing
- All outputs are registered. The state, counters and table reside in the `Sys_Clk0` domain.
- Input latency:
  - `skip_i` sampled at edge n gives RESYNC at n+1 and the new mask at n+2.
  - `enable_i` rising gives RESYNC on the next cycle.
- Natural advance period, measured between `advance_o` pulses: CYCLES_PER_PATTERN × 2^(PWM_BITS+1) × P + 1 clocks (the +1 is the RESYNC cycle).
- A period of 0 behaves exactly as a period of 1.
- `cyc_cnt` is 8 bits wide. `clk_cnt` and `step_cnt` never exceed their terminal values.
- Assertion of `Sys_Clk0_Rst` mid-operation forces all reset values asynchronously. The block restarts from IDLE after deassertion.

## Structure
- Package `breathe_seq_pkg`:
  - `rgb_mask_t` (3-bit).
  - Colour constants: RED, GREEN, BLUE, YELLOW, MAGENTA, CYAN, WHITE, OFF.
  - State enum.
  - Default table constant.
- Sub-module `breathe_timebase`: the `clk_cnt`/`step_cnt`/`cyc_cnt` chain, with inputs clear and hold and output `cycle_end`.
- Top level: FSM, pattern table (flops, NUM_ENTRIES × 3), period shadow register, output registers.

## Test plan
Unless a scenario states otherwise, the bench uses PWM_BITS=2, CYCLES_PER_PATTERN=1, period=2, so one breathe cycle is 16 clocks.

- Release reset, then raise `enable_i` -> after RESYNC, `chan_rst_o` = 3'b011 (blue breathing); `advance_o` pulses every 17 clocks; `entry_o` runs 0..7 and wraps to 0.
- Write period=4 mid-cycle -> `period_o` stays 2 until the next RESYNC, then becomes 4; the next advance interval is 33 clocks.
- Pulse `skip_i` at clock 5 of entry 0 -> RESYNC at clock 6; `entry_o` = 1; `chan_rst_o` = 3'b101 (green).
- Hold `pause_i` for 40 clocks -> `chan_rst_o` and `entry_o` are frozen. Pulse `skip_i` during the pause -> `entry_o` increments with no RESYNC until `pause_i` falls.
- Write entry 2 = 3'b000 while the sequence is at entry 1 -> on reaching entry 2, `chan_rst_o` = 3'b111 for 16 clocks.
- Assert `Sys_Clk0_Rst` mid-RUN -> all outputs return to reset values immediately. Drop `enable_i` instead -> IDLE next cycle with `entry_o` = 0.
